dmem_responder: RTL and testbench

- Data-memory responder: the target side of the processor's memory-stage read/write interface.
- Accepts one read or write request at a time from the memory stage, holds 64-bit word storage, returns read data or an address-error flag after a programmable latency.
- `req_ready` low tells the memory-stage control logic to stall; `resp_err` drives `dmem_error` (status `sadr`).

---
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding read/write target with DEPTH x 64-bit
// storage and a fixed response latency. Define DMEM_ALIGN_CHECK_EN for byte addressing.
module dmem_responder #(
    parameter int DEPTH   = 16,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [63:0] DEPTH_W = 64'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              pend_write_reg;
    logic              pend_err_reg;
    logic [IDX_W-1:0]  pend_idx_reg;
    logic [63:0]       pend_wdata_reg;
    logic [63:0]       mem_reg [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic [IDX_W-1:0]  req_idx;
    logic              req_err;
    logic              commit_write;
    logic              commit_err;
    logic [IDX_W-1:0]  commit_idx;
    logic [63:0]       commit_wdata;
    logic              do_write;
    logic [63:0]       read_word;

`ifdef DMEM_ALIGN_CHECK_EN
    logic [63:0] word_addr;
    assign word_addr = {3'b000, req_addr[63:3]};
    assign req_err   = (req_addr[2:0] != 3'b000) || (word_addr >= DEPTH_W);
    assign req_idx   = word_addr[IDX_W-1:0];
`else
    assign req_err   = (req_addr >= DEPTH_W);
    assign req_idx   = req_addr[IDX_W-1:0];
`endif

    assign req_ready = (state_reg != WAIT);
    assign busy      = (state_reg != IDLE);
    assign accept    = req_valid && req_ready;

    // With LATENCY == 1 the acceptance edge is also the commit edge, so the
    // commit operands come straight from the request rather than the latches.
    assign enter_resp   = (accept && (LATENCY == 1)) ||
                          ((state_reg == WAIT) && (cnt_reg == CNT_W'(1)));
    assign commit_write = accept ? req_write : pend_write_reg;
    assign commit_err   = accept ? req_err   : pend_err_reg;
    assign commit_idx   = accept ? req_idx   : pend_idx_reg;
    assign commit_wdata = accept ? req_wdata : pend_wdata_reg;
    assign do_write     = enter_resp && commit_write && !commit_err;
    assign read_word    = mem_reg[commit_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_write) begin
            mem_reg[commit_idx] <= commit_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            pend_write_reg <= 1'b0;
            pend_err_reg   <= 1'b0;
            pend_idx_reg   <= '0;
            pend_wdata_reg <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
        end else begin
            resp_valid <= enter_resp;
            if (accept) begin
                pend_write_reg <= req_write;
                pend_err_reg   <= req_err;
                pend_idx_reg   <= req_idx;
                pend_wdata_reg <= req_wdata;
            end
            if (enter_resp) begin
                resp_err   <= commit_err;
                resp_rdata <= (commit_write || commit_err) ? 64'd0 : read_word;
            end
            case (state_reg)
                IDLE, RESP: begin
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_W'(LATENCY - 1);
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 3, 4) sharing stimulus,
// with a response scoreboard fed from a reference memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;

    logic        ready_a [3];
    logic        valid_a [3];
    logic        err_a   [3];
    logic        busy_a  [3];
    logic [63:0] rdata_a [3];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            dmem_responder #(
                .DEPTH  (16),
                .LATENCY((gi == 0) ? 1 : ((gi == 1) ? 3 : 4))
            ) dut (
                .clk       (clk),
                .reset_n   (reset_n),
                .req_valid (req_valid),
                .req_write (req_write),
                .req_addr  (req_addr),
                .req_wdata (req_wdata),
                .req_ready (ready_a[gi]),
                .resp_valid(valid_a[gi]),
                .resp_rdata(rdata_a[gi]),
                .resp_err  (err_a[gi]),
                .busy      (busy_a[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sel = 0;

    logic        obs_ready, obs_valid, obs_err, obs_busy;
    logic [63:0] obs_rdata;

    always_comb begin
        obs_ready = ready_a[sel];
        obs_valid = valid_a[sel];
        obs_err   = err_a[sel];
        obs_busy  = busy_a[sel];
        obs_rdata = rdata_a[sel];
    end

    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model [16];

    function automatic int lat_of(input int s);
        case (s)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_err(input logic [63:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a[2:0] != 3'b000) || ((a >> 3) >= 64'd16);
`else
        return a >= 64'd16;
`endif
    endfunction

    function automatic int model_idx(input logic [63:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return int'(a[6:3]);
`else
        return int'(a[3:0]);
`endif
    endfunction

    // Scoreboard: every response of the observed instance is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && obs_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp cyc=%0d rdata=%h err=%b", cyc, obs_rdata, obs_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (obs_rdata !== e.rdata || obs_err !== e.err || cyc !== e.due) begin
                    errors++;
                    $display("FAIL resp got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                             obs_rdata, obs_err, cyc, e.rdata, e.err, e.due);
                end else begin
                    $display("resp dut%0d cyc=%0d rdata=%h err=%b", sel, cyc, obs_rdata, obs_err);
                end
            end
        end
    end

    task automatic clear_model();
        sb_q.delete();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_req(input logic wr, input logic [63:0] a, input logic [63:0] d);
        exp_t e;
        int   n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (obs_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (obs_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout ready=%b required 1", obs_ready);
        end
        e.err   = model_err(a);
        e.rdata = '0;
        if (!e.err) begin
            if (wr) model[model_idx(a)] = d;
            else    e.rdata = model[model_idx(a)];
        end
        e.due = cyc + lat_of(sel);
        sb_q.push_back(e);
        $display("req dut%0d cyc=%0d %s addr=%h wdata=%h", sel, cyc, wr ? "WR" : "RD", a, d);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        #1;
        while (sb_q.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ready_a[i], valid_a[i], err_a[i], busy_a[i]} !== 4'b1000 || rdata_a[i] !== 64'd0) begin
                errors++;
                $display("FAIL reset dut%0d got rdy/vld/err/busy=%b%b%b%b rdata=%h required 1000 rdata=0",
                         i, ready_a[i], valid_a[i], err_a[i], busy_a[i], rdata_a[i]);
            end
        end
    endtask

    task automatic test_basic();
        sel = 0;
        reset_pulse();
        drive_req(1'b1, 64'd3, 64'hDEAD_BEEF);
        @(negedge clk);
        drive_req(1'b0, 64'd3, 64'd0);
        drain();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL basic_drain pending=%0d required 0", sb_q.size());
        end
    endtask

    task automatic test_latency3();
        logic exp_ready [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_busy  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic exp_valid [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        sel = 1;
        reset_pulse();
        drive_req(1'b0, 64'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_ready !== exp_ready[i] || obs_busy !== exp_busy[i] || obs_valid !== exp_valid[i]) begin
                errors++;
                $display("FAIL lat3_step%0d got rdy/busy/vld=%b%b%b required %b%b%b", i,
                         obs_ready, obs_busy, obs_valid, exp_ready[i], exp_busy[i], exp_valid[i]);
            end
            @(negedge clk);
        end
        drain();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL lat3_drain pending=%0d required 0", sb_q.size());
        end
    endtask

    task automatic test_range();
        sel = 0;
        reset_pulse();
        drive_req(1'b1, 64'd16, 64'd5);
        @(negedge clk);
        drive_req(1'b0, 64'd0, 64'd0);
        drive_req(1'b1, 64'd15, 64'hA5A5);
        drive_req(1'b0, 64'd15, 64'd0);
        drive_req(1'b0, 64'h8000_0000_0000_0000, 64'd0);
        drive_req(1'b1, 64'h0000_0001_0000_0002, 64'd77);
        drive_req(1'b0, 64'd2, 64'd0);
        drain();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL range_drain pending=%0d required 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        reset_pulse();
        drive_req(1'b1, 64'd7, 64'h1234);
        drive_req(1'b0, 64'd7, 64'd0);
        checks++;
        if (obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_valid got %b required 1", obs_valid);
        end
        drain();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_drain pending=%0d required 0", sb_q.size());
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        sel = 2;
        reset_pulse();
        drive_req(1'b1, 64'd2, 64'd9);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_async got busy=%b vld=%b required 0 0", obs_busy, obs_valid);
        end
        clear_model();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (obs_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midop_no_resp got %0d responses required 0", seen);
        end
        drive_req(1'b0, 64'd2, 64'd0);
        drain();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL midop_drain pending=%0d required 0", sb_q.size());
        end
    endtask

`ifdef DMEM_ALIGN_CHECK_EN
    task automatic test_align();
        sel = 0;
        reset_pulse();
        drive_req(1'b1, 64'h18, 64'd77);
        drive_req(1'b0, 64'h18, 64'd0);
        drive_req(1'b0, 64'h1C, 64'd0);
        drive_req(1'b1, 64'h21, 64'd3);
        drive_req(1'b0, 64'h20, 64'd0);
        drain();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL align_drain pending=%0d required 0", sb_q.size());
        end
    endtask
`endif

    initial begin
        clear_model();
        test_reset();
        test_basic();
        test_reset();
        test_latency3();
        test_range();
        test_back_to_back();
        test_reset_midop();
`ifdef DMEM_ALIGN_CHECK_EN
        test_align();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench did not complete");
    end

endmodule
